// File: rtl/pipe_ctrl.sv
// Pipeline hazard/halt controller: stall, flush and drain sequencing for a 5-stage core,
// plus saturating stall and redirect-flush event counters.
module pipe_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_rs1_used,
    input  logic        id_rs2_used,
    input  logic [4:0]  ex_rd,
    input  logic        ex_memread,
    input  logic        ex_halt,
    input  logic        ex_redirect,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        id_ex_write,
    output logic        ex_mem_write,
    output logic        mem_wb_write,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        halted,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  drain_q, drain_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic        halted_q, halted_d;

    logic mem_wait;
    logic rs1_hit, rs2_hit, load_use;
    logic stall_inc, flush_inc;

    always_comb begin
        mem_wait = mem_req & ~mem_ready;
        rs1_hit  = id_rs1_used & (id_rs1 == ex_rd);
        rs2_hit  = id_rs2_used & (id_rs2 == ex_rd);
        // x0 is never written, so a load targeting it can never create a hazard
        load_use = ex_memread & (ex_rd != 5'd0) & (rs1_hit | rs2_hit);
    end

    always_comb begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_write  = 1'b0;
        ex_mem_write = 1'b0;
        mem_wb_write = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        state_d      = state_q;
        drain_d      = drain_q;
        halted_d     = halted_q;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;

        if (mem_wait) begin
            // Whole pipeline freezes; FSM and drain counter hold
            stall_inc = (state_q != HALTED);
        end else begin
            case (state_q)
                RUN: begin
                    if (ex_halt) begin
                        if_id_flush  = 1'b1;
                        id_ex_flush  = 1'b1;
                        if_id_write  = 1'b1;
                        id_ex_write  = 1'b1;
                        ex_mem_write = 1'b1;
                        mem_wb_write = 1'b1;
                        state_d      = DRAIN;
                        drain_d      = 2'd2;
                    end else if (ex_redirect) begin
                        pc_write     = 1'b1;
                        if_id_write  = 1'b1;
                        id_ex_write  = 1'b1;
                        ex_mem_write = 1'b1;
                        mem_wb_write = 1'b1;
                        if_id_flush  = 1'b1;
                        id_ex_flush  = 1'b1;
                        flush_inc    = 1'b1;
                    end else if (load_use) begin
                        // Hold PC and IF/ID, inject one bubble into ID/EX
                        id_ex_write  = 1'b1;
                        id_ex_flush  = 1'b1;
                        ex_mem_write = 1'b1;
                        mem_wb_write = 1'b1;
                        stall_inc    = 1'b1;
                    end else begin
                        pc_write     = 1'b1;
                        if_id_write  = 1'b1;
                        id_ex_write  = 1'b1;
                        ex_mem_write = 1'b1;
                        mem_wb_write = 1'b1;
                    end
                end
                DRAIN: begin
                    if_id_flush  = 1'b1;
                    id_ex_flush  = 1'b1;
                    if_id_write  = 1'b1;
                    id_ex_write  = 1'b1;
                    ex_mem_write = 1'b1;
                    mem_wb_write = 1'b1;
                    if (drain_q <= 2'd1) begin
                        drain_d  = 2'd0;
                        state_d  = HALTED;
                        halted_d = 1'b1;
                    end else begin
                        drain_d  = drain_q - 2'd1;
                    end
                end
                HALTED: begin
                    halted_d = 1'b1;
                end
                default: begin
                    state_d  = RUN;
                    drain_d  = 2'd0;
                    halted_d = 1'b0;
                end
            endcase
        end

        stall_cnt_d = (stall_inc && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
        flush_cnt_d = (flush_inc && flush_cnt_q != 16'hFFFF) ? flush_cnt_q + 16'd1 : flush_cnt_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            drain_q     <= 2'd0;
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            halted_q    <= halted_d;
        end
    end

    assign halted    = halted_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
